// File: rtl/bcd_multi_digit_timer_if.sv
// rtl/bcd_multi_digit_timer_if.sv - control/status bundle for bcd_multi_digit_timer
//
// Groups the timer's control inputs, count/status outputs and display scanner
// outputs into one bundle.
//   master : pin wrapper side (drives controls, observes status/display)
//   slave  : timer side
// Signals:
//   ena, load, start, pause, dir, auto_reload : control strobes/levels
//   preset_in  [4*DIGITS] : BCD preset, digit 0 in [3:0]
//   count_out  [4*DIGITS] : current BCD count
//   time_out, done_pulse, running : status
//   disp_sel [DIGITS], disp_bcd [4] : multiplexed display scan

interface bcd_multi_digit_timer_if #(
  parameter int DIGITS = 2
);
  logic                  ena;
  logic                  load;
  logic                  start;
  logic                  pause;
  logic                  dir;
  logic                  auto_reload;
  logic [4*DIGITS-1:0]   preset_in;
  logic [4*DIGITS-1:0]   count_out;
  logic                  time_out;
  logic                  done_pulse;
  logic                  running;
  logic [DIGITS-1:0]     disp_sel;
  logic [3:0]            disp_bcd;

  modport master (
    output ena, load, start, pause, dir, auto_reload, preset_in,
    input  count_out, time_out, done_pulse, running, disp_sel, disp_bcd
  );

  modport slave (
    input  ena, load, start, pause, dir, auto_reload, preset_in,
    output count_out, time_out, done_pulse, running, disp_sel, disp_bcd
  );
endinterface

// File: rtl/bcd_multi_digit_timer.sv
// rtl/bcd_multi_digit_timer.sv - N-digit BCD interval timer with display scanner
//
// Counts up (0 -> preset) or down (preset -> 0) in BCD, one step per TICK_DIV
// clocks, with pause/resume and optional auto-reload. A free-running scanner
// presents one digit at a time for a shared 7-segment decoder.
// Ports:
//   clk    : single clock
//   rst_n  : asynchronous active-low reset
//   tmr    : control/status bundle (slave side), see bcd_multi_digit_timer_if

module bcd_multi_digit_timer #(
  parameter int DIGITS    = 2,
  parameter int TICK_DIV  = 10_000_000,
  parameter int SCAN_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_multi_digit_timer_if.slave   tmr
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Per-nibble saturation so a non-BCD preset still yields a legal count range.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // Ripple carry across digits: a 9 rolls to 0 and the carry moves on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple borrow across digits: a 0 rolls to 9 and the borrow moves on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Timer state
  state_e          state_q, state_d;
  logic [W-1:0]    preset_q, preset_d;
  logic            dir_q, dir_d;
  logic [W-1:0]    count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            time_out_q, time_out_d;
  logic            done_q, done_d;
  logic            running_q, running_d;

  // Scanner state
  logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0]    disp_sel_q, disp_sel_d;
  logic [3:0]           disp_bcd_q, disp_bcd_d;

  // Gated controls
  logic         ld, ps, st;
  logic         tick;
  logic [W-1:0] start_val, term_val, stepped, load_preset;

  always_comb begin
    ld          = tmr.ena & tmr.load;
    ps          = tmr.ena & tmr.pause;
    st          = tmr.ena & tmr.start;
    tick        = (presc_q == PRESC_LAST);
    start_val   = dir_q ? preset_q : '0;
    term_val    = dir_q ? '0 : preset_q;
    stepped     = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);
    load_preset = bcd_clamp(tmr.preset_in);
  end

  // Next-state / datapath for the timer FSM. Strict priority load > pause >
  // start: an asserted pause masks start in every state.
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    dir_d    = dir_q;
    count_d  = count_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (ld) begin
      preset_d = load_preset;
      dir_d    = tmr.dir;
      count_d  = tmr.dir ? load_preset : '0;
      presc_d  = '0;
      state_d  = S_IDLE;
    end else if (ps) begin
      // A tick landing on this cycle is dropped: count and prescaler hold.
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (st && (state_q == S_IDLE || state_q == S_DONE)) begin
      count_d = start_val;
      presc_d = '0;
      if (start_val == term_val) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else if (st && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        // Sitting on the terminal value while running only happens under
        // auto-reload; that tick restores the start value instead of stepping.
        if (count_q == term_val) begin
          count_d = start_val;
        end else begin
          count_d = stepped;
          if (stepped == term_val) begin
            done_d = 1'b1;
            if (!tmr.auto_reload) state_d = S_DONE;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    time_out_d = (state_d == S_DONE);
    running_d  = (state_d == S_RUN);
  end

  // Scanner: the display registers sample the current count and index, so
  // they trail count_out by one cycle.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_BITS'(1);
    idx_d      = idx_q;
    if (&scan_cnt_q) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    disp_sel_d = '0;
    disp_bcd_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        disp_sel_d[i] = 1'b1;
        disp_bcd_d    = count_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      preset_q   <= '0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      presc_q    <= '0;
      time_out_q <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      time_out_q <= time_out_d;
      done_q     <= done_d;
      running_q  <= running_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      disp_sel_q <= DIGITS'(1);
      disp_bcd_q <= 4'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      disp_sel_q <= disp_sel_d;
      disp_bcd_q <= disp_bcd_d;
    end
  end

  assign tmr.count_out  = count_q;
  assign tmr.time_out   = time_out_q;
  assign tmr.done_pulse = done_q;
  assign tmr.running    = running_q;
  assign tmr.disp_sel   = disp_sel_q;
  assign tmr.disp_bcd   = disp_bcd_q;

endmodule

// File: tb/tb_bcd_multi_digit_timer.sv
// tb/tb_bcd_multi_digit_timer.sv - self-checking bench for bcd_multi_digit_timer

module tb_bcd_multi_digit_timer;

  localparam int DIGITS    = 2;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_BITS = 2;
  localparam int W         = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_multi_digit_timer_if #(.DIGITS(DIGITS)) tif ();

  bcd_multi_digit_timer #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_BITS(SCAN_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tmr(tif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers, states 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int m_state, m_preset, m_dir, m_count, m_presc, m_scnt, m_idx, m_sel, m_bcd;
  bit m_dp;

  typedef struct {
    logic ena, load, start, pause, dir, ar;
    logic [W-1:0] preset;
    logic [W-1:0] e_count;
    logic e_to, e_dp, e_run;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec_of(input logic [W-1:0] v);
    int r, p;
    logic [3:0] n;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = v[4*i +: 4];
      if (n > 4'd9) r += 9 * p;
      else r += int'(n) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_of(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_preset = 0; m_dir = 0; m_count = 0; m_presc = 0;
    m_scnt = 0; m_idx = 0; m_sel = 1; m_bcd = 0; m_dp = 0;
  endtask

  task automatic model_edge();
    int sv, tv, old_count;
    bit ld, ps, st;
    old_count = m_count;
    ld = tif.ena && tif.load;
    ps = tif.ena && tif.pause;
    st = tif.ena && tif.start;
    sv = m_dir ? m_preset : 0;
    tv = m_dir ? 0 : m_preset;
    m_dp = 0;
    if (ld) begin
      m_preset = dec_of(tif.preset_in);
      m_dir = int'(tif.dir);
      m_count = m_dir ? m_preset : 0;
      m_presc = 0;
      m_state = 0;
    end else if (ps) begin
      if (m_state == 1) m_state = 2;
    end else if (st && (m_state == 0 || m_state == 3)) begin
      m_count = sv;
      m_presc = 0;
      if (sv == tv) begin m_state = 3; m_dp = 1; end
      else m_state = 1;
    end else if (st && m_state == 2) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_presc = (m_presc + 1) % TICK_DIV;
      if (m_presc == 0) begin
        if (m_count == tv) m_count = sv;
        else begin
          m_count += m_dir ? -1 : 1;
          if (m_count == tv) begin
            m_dp = 1;
            if (!tif.auto_reload) m_state = 3;
          end
        end
      end
    end
    m_sel = 1 << m_idx;
    m_bcd = (old_count / (10 ** m_idx)) % 10;
    m_scnt = (m_scnt + 1) % (1 << SCAN_BITS);
    if (m_scnt == 0) m_idx = (m_idx + 1) % DIGITS;
  endtask

  task automatic step();
    logic [63:0] act, exp;
    @(posedge clk);
    model_edge();
    #1;
    act = 64'({tif.count_out, tif.time_out, tif.done_pulse, tif.running, tif.disp_sel, tif.disp_bcd});
    exp = 64'({bcd_of(m_count), (m_state == 3), m_dp, (m_state == 1), DIGITS'(m_sel), 4'(m_bcd)});
    chk("lockstep", act, exp);
  endtask

  task automatic set_in(input logic e, l, s, p, d, a, input logic [W-1:0] pr);
    tif.ena = e; tif.load = l; tif.start = s; tif.pause = p;
    tif.dir = d; tif.auto_reload = a; tif.preset_in = pr;
  endtask

  task automatic idle();
    tif.load = 0; tif.start = 0; tif.pause = 0; tif.ena = 1;
  endtask

  initial begin
    int dp_cnt, to_seen, changed, last_edge, gap;
    logic [DIGITS-1:0] prev_sel;

    set_in(0, 0, 0, 0, 0, 0, '0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", tif.count_out, 0);
    chk("reset_time_out", tif.time_out, 0);
    chk("reset_done_pulse", tif.done_pulse, 0);
    chk("reset_running", tif.running, 0);
    chk("reset_disp_sel", tif.disp_sel, 1);
    chk("reset_disp_bcd", tif.disp_bcd, 0);
    @(negedge clk) rst_n = 1'b1;

    // Boundary vectors: {ena,load,start,pause,dir,ar,preset} -> {count,to,dp,run}
    vt[0]  = '{1, 1, 0, 0, 1, 0, 8'hAF, 8'h99, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 0, 0, 0, 8'h00, 8'h99, 0, 0, 0};
    vt[2]  = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1};
    vt[3]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h99, 0, 0, 1};
    vt[4]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h99, 0, 0, 0};
    vt[5]  = '{1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    vt[6]  = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0};
    vt[7]  = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0};
    vt[8]  = '{1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0};
    vt[9]  = '{1, 1, 1, 0, 1, 0, 8'h05, 8'h05, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0};
    vt[11] = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h05, 0, 0, 1};
    vt[12] = '{1, 1, 0, 0, 0, 0, 8'h3A, 8'h00, 0, 0, 0};
    vt[13] = '{0, 1, 0, 0, 1, 0, 8'h12, 8'h00, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].ena, vt[i].load, vt[i].start, vt[i].pause, vt[i].dir, vt[i].ar, vt[i].preset);
      step();
      chk($sformatf("vec%0d_count", i), tif.count_out, vt[i].e_count);
      chk($sformatf("vec%0d_flags", i), {tif.time_out, tif.done_pulse, tif.running},
          {vt[i].e_to, vt[i].e_dp, vt[i].e_run});
    end

    // Up count 00..12
    set_in(1, 1, 0, 0, 0, 0, 8'h12); step();
    set_in(1, 0, 1, 0, 0, 0, 8'h12); step();
    idle();
    dp_cnt = 0;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (tif.done_pulse) dp_cnt++;
      if (k == 36) chk("up_09", tif.count_out, 8'h09);
      if (k == 40) chk("up_10", tif.count_out, 8'h10);
      if (k == 47) chk("up_11", {tif.count_out, tif.done_pulse}, {8'h11, 1'b0});
      if (k == 48) chk("up_term", {tif.count_out, tif.done_pulse, tif.time_out, tif.running},
                       {8'h12, 1'b1, 1'b1, 1'b0});
      if (k == 52) chk("up_hold", {tif.count_out, tif.done_pulse, tif.time_out}, {8'h12, 1'b0, 1'b1});
    end
    chk("up_dp_once", dp_cnt, 1);

    // Down with auto-reload
    set_in(1, 1, 0, 0, 1, 1, 8'h03); step();
    set_in(1, 0, 1, 0, 1, 1, 8'h03); step();
    idle();
    dp_cnt = 0;
    to_seen = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (tif.done_pulse) dp_cnt++;
      if (tif.time_out) to_seen++;
      if (k == 12) chk("ar_zero", {tif.count_out, tif.done_pulse, tif.running}, {8'h00, 1'b1, 1'b1});
      if (k == 16) chk("ar_reload", tif.count_out, 8'h03);
      if (k == 20) chk("ar_02", tif.count_out, 8'h02);
      if (k == 28) chk("ar_zero2", {tif.count_out, tif.done_pulse}, {8'h00, 1'b1});
    end
    chk("ar_dp_count", dp_cnt, 2);
    chk("ar_no_time_out", to_seen, 0);

    // Pause / resume
    set_in(1, 1, 0, 0, 0, 0, 8'h12); step();
    set_in(1, 0, 1, 0, 0, 0, 8'h12); step();
    idle();
    repeat (6) step();
    chk("pr_before", tif.count_out, 8'h01);
    tif.pause = 1; step(); tif.pause = 0;
    chk("pr_paused", {tif.count_out, tif.running}, {8'h01, 1'b0});
    changed = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tif.count_out !== 8'h01) changed++;
    end
    chk("pr_frozen", changed, 0);
    tif.start = 1; step(); tif.start = 0;
    chk("pr_resumed", {tif.count_out, tif.running}, {8'h01, 1'b1});
    step();
    chk("pr_no_early_tick", tif.count_out, 8'h01);
    step();
    chk("pr_tick_after_2", tif.count_out, 8'h02);
    repeat (3) step();
    tif.pause = 1; step(); tif.pause = 0;
    chk("pr_tick_dropped", tif.count_out, 8'h02);
    tif.start = 1; step(); tif.start = 0;
    step();
    chk("pr_tick_after_drop", tif.count_out, 8'h03);

    // Scanner on a stable count of 37
    set_in(1, 1, 0, 0, 1, 0, 8'h37); step();
    idle(); step();
    prev_sel = tif.disp_sel;
    last_edge = -1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("scan_bcd", tif.disp_bcd, (tif.disp_sel == 2'b01) ? 4'd7 : 4'd3);
      if (tif.disp_sel !== prev_sel) begin
        if (last_edge >= 0) begin
          gap = k - last_edge;
          chk("scan_period", gap, 4);
        end
        last_edge = k;
      end
      prev_sel = tif.disp_sel;
    end

    // Asynchronous reset mid-RUN
    set_in(1, 1, 0, 0, 0, 0, 8'h12); step();
    set_in(1, 0, 1, 0, 0, 0, 8'h12); step();
    idle();
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", tif.count_out, 0);
    chk("arst_flags", {tif.time_out, tif.running, tif.done_pulse}, 3'b000);
    chk("arst_disp_sel", tif.disp_sel, 2'b01);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) step();

    // Randomized traffic against the model
    tif.auto_reload = 0;
    for (int k = 0; k < 3000; k++) begin
      tif.ena   = ($urandom % 8) != 0;
      tif.load  = ($urandom % 40) == 0;
      tif.start = ($urandom % 10) == 0;
      tif.pause = ($urandom % 25) == 0;
      tif.dir   = $urandom % 2;
      if (($urandom % 50) == 0) tif.auto_reload = ~tif.auto_reload;
      tif.preset_in = (($urandom % 3) == 0) ? W'($urandom) : W'($urandom % 16);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
